// File: rtl/cmd_packer.sv
// ---------------------------------------------------------------------------
// cmd_packer
//
// Host-side writer for the command FIFO drained by the command sequencer.
// One decoded layer descriptor is taken per valid/ready handshake, checked,
// and serialized into the 6-word x 32-bit compressed command format while
// honouring FIFO backpressure.  The running command count (cmd_size) is kept
// here; sealing the list produces a single-cycle op_en start pulse.
//
// Ports
//   clk, rst_n          system clock, asynchronous active-low reset
//   desc_valid/ready    descriptor handshake
//   op_type .. writeback_addr
//                       descriptor fields, sampled on an accepted handshake
//   seal                pulse: list complete, start execution
//   clear               pulse: drop count and errors, reopen the list
//   cmd_fifo_full       FIFO backpressure
//   cmd_fifo_wr_en/din  FIFO write port
//   cmd_size            commands written in the current list
//   op_en               single-cycle start pulse
//   busy                packer is not idle
//   err_bad_op          sticky: descriptor with op_type 0/6/7 rejected
//   err_overflow        sticky: descriptor rejected because the list is full
// ---------------------------------------------------------------------------
module cmd_packer #(
    parameter int CMD_BURST_LEN = 6,
    parameter int MAX_CMDS      = 127
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        desc_valid,
    output logic        desc_ready,
    input  logic [2:0]  op_type,
    input  logic        padding,
    input  logic [7:0]  stride_1,
    input  logic [15:0] stride_2,
    input  logic [15:0] i_channel_size,
    input  logic [15:0] o_channel_size,
    input  logic [7:0]  i_kernel_size,
    input  logic [7:0]  o_kernel_size,
    input  logic [31:0] weight_start_addr,
    input  logic [31:0] data_start_addr,
    input  logic [31:0] writeback_addr,
    input  logic        seal,
    input  logic        clear,
    input  logic        cmd_fifo_full,
    output logic        cmd_fifo_wr_en,
    output logic [31:0] cmd_fifo_din,
    output logic [6:0]  cmd_size,
    output logic        op_en,
    output logic        busy,
    output logic        err_bad_op,
    output logic        err_overflow
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        START  = 2'd2,
        SEALED = 2'd3
    } state_t;

    localparam logic [2:0] LAST_BEAT = 3'(CMD_BURST_LEN - 1);
    localparam logic [6:0] CMD_LIMIT = 7'(MAX_CMDS);

    state_t      state;
    logic [2:0]  beat;
    logic        pending_seal;

    // Shadow copy of the accepted descriptor; the host may change its
    // inputs as soon as the handshake completes.
    logic [2:0]  sh_op;
    logic        sh_pad;
    logic [7:0]  sh_s1;
    logic [15:0] sh_s2;
    logic [15:0] sh_ich;
    logic [15:0] sh_och;
    logic [7:0]  sh_ik;
    logic [7:0]  sh_ok;
    logic [31:0] sh_wa;
    logic [31:0] sh_da;
    logic [31:0] sh_wb;

    logic desc_fire;
    logic op_legal;
    logic has_room;
    logic accept;
    logic reject;

    assign desc_fire = desc_valid & desc_ready;
    assign op_legal  = (op_type != 3'd0) && (op_type <= 3'd5);
    assign has_room  = (cmd_size != CMD_LIMIT);

    // A clear in the same cycle empties the list, so a legal descriptor
    // always fits; a rejected one leaves no error behind because clear wins.
    assign accept = desc_fire && op_legal && (has_room || clear);
    assign reject = desc_fire && !accept && !clear;

    // Write strobe follows backpressure directly so a deasserting full
    // costs no extra cycle.
    assign cmd_fifo_wr_en = (state == SEND) && !cmd_fifo_full;

    // Beat-selected word; held stable while full stalls the beat counter.
    always_comb begin
        cmd_fifo_din = '0;
        if (state == SEND) begin
            case (beat)
                3'd0:    cmd_fifo_din = {sh_s2, sh_s1, 4'h0, sh_pad, sh_op};
                3'd1:    cmd_fifo_din = {sh_och, sh_ich};
                3'd2:    cmd_fifo_din = {8'h00, sh_ok, 8'h00, sh_ik};
                3'd3:    cmd_fifo_din = sh_wa;
                3'd4:    cmd_fifo_din = sh_da;
                3'd5:    cmd_fifo_din = sh_wb;
                default: cmd_fifo_din = '0;
            endcase
        end
    end

    // desc_ready and busy are registered alongside the state so they read 0
    // throughout reset and change on the same edge as the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            beat         <= '0;
            pending_seal <= 1'b0;
            desc_ready   <= 1'b0;
            busy         <= 1'b0;
            op_en        <= 1'b0;
            cmd_size     <= '0;
            err_bad_op   <= 1'b0;
            err_overflow <= 1'b0;
            sh_op        <= '0;
            sh_pad       <= 1'b0;
            sh_s1        <= '0;
            sh_s2        <= '0;
            sh_ich       <= '0;
            sh_och       <= '0;
            sh_ik        <= '0;
            sh_ok        <= '0;
            sh_wa        <= '0;
            sh_da        <= '0;
            sh_wb        <= '0;
        end else begin
            op_en <= 1'b0;
            case (state)
                IDLE: begin
                    desc_ready <= 1'b1;
                    busy       <= 1'b0;
                    if (clear) begin
                        cmd_size     <= '0;
                        err_bad_op   <= 1'b0;
                        err_overflow <= 1'b0;
                    end
                    if (accept) begin
                        sh_op        <= op_type;
                        sh_pad       <= padding;
                        sh_s1        <= stride_1;
                        sh_s2        <= stride_2;
                        sh_ich       <= i_channel_size;
                        sh_och       <= o_channel_size;
                        sh_ik        <= i_kernel_size;
                        sh_ok        <= o_kernel_size;
                        sh_wa        <= weight_start_addr;
                        sh_da        <= data_start_addr;
                        sh_wb        <= writeback_addr;
                        beat         <= '0;
                        // A seal alongside an accepted descriptor is
                        // remembered and honoured once the burst finishes.
                        pending_seal <= seal && !clear;
                        state        <= SEND;
                        desc_ready   <= 1'b0;
                        busy         <= 1'b1;
                    end else begin
                        if (reject) begin
                            if (!op_legal) err_bad_op   <= 1'b1;
                            else           err_overflow <= 1'b1;
                        end
                        if (seal && !clear && (cmd_size != 7'd0)) begin
                            state      <= START;
                            op_en      <= 1'b1;
                            desc_ready <= 1'b0;
                            busy       <= 1'b1;
                        end
                    end
                end

                SEND: begin
                    if (seal) pending_seal <= 1'b1;
                    if (cmd_fifo_wr_en) begin
                        if (beat == LAST_BEAT) begin
                            beat     <= '0;
                            cmd_size <= cmd_size + 7'd1;
                            // seal landing on the last beat counts too
                            if (pending_seal || seal) begin
                                state <= START;
                                op_en <= 1'b1;
                            end else begin
                                state      <= IDLE;
                                desc_ready <= 1'b1;
                                busy       <= 1'b0;
                            end
                        end else begin
                            beat <= beat + 3'd1;
                        end
                    end
                end

                START: begin
                    pending_seal <= 1'b0;
                    state        <= SEALED;
                end

                SEALED: begin
                    if (clear) begin
                        cmd_size     <= '0;
                        err_bad_op   <= 1'b0;
                        err_overflow <= 1'b0;
                        state        <= IDLE;
                        desc_ready   <= 1'b1;
                        busy         <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_packer.sv
// ---------------------------------------------------------------------------
// tb_cmd_packer
//
// Directed bench for cmd_packer.  A monitor on every falling edge compares
// the FIFO write stream against a queue of expected words built from each
// accepted descriptor, and compares cmd_size and the sticky errors against
// a count/flag model.  Directed sequences add literal expectations.
// ---------------------------------------------------------------------------
module tb_cmd_packer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        desc_valid = 1'b0;
    logic        desc_ready;
    logic [2:0]  op_type = '0;
    logic        padding = 1'b0;
    logic [7:0]  stride_1 = '0;
    logic [15:0] stride_2 = '0;
    logic [15:0] i_channel_size = '0;
    logic [15:0] o_channel_size = '0;
    logic [7:0]  i_kernel_size = '0;
    logic [7:0]  o_kernel_size = '0;
    logic [31:0] weight_start_addr = '0;
    logic [31:0] data_start_addr = '0;
    logic [31:0] writeback_addr = '0;
    logic        seal = 1'b0;
    logic        clear = 1'b0;
    logic        cmd_fifo_full = 1'b0;
    logic        cmd_fifo_wr_en;
    logic [31:0] cmd_fifo_din;
    logic [6:0]  cmd_size;
    logic        op_en;
    logic        busy;
    logic        err_bad_op;
    logic        err_overflow;

    cmd_packer dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .desc_valid        (desc_valid),
        .desc_ready        (desc_ready),
        .op_type           (op_type),
        .padding           (padding),
        .stride_1          (stride_1),
        .stride_2          (stride_2),
        .i_channel_size    (i_channel_size),
        .o_channel_size    (o_channel_size),
        .i_kernel_size     (i_kernel_size),
        .o_kernel_size     (o_kernel_size),
        .weight_start_addr (weight_start_addr),
        .data_start_addr   (data_start_addr),
        .writeback_addr    (writeback_addr),
        .seal              (seal),
        .clear             (clear),
        .cmd_fifo_full     (cmd_fifo_full),
        .cmd_fifo_wr_en    (cmd_fifo_wr_en),
        .cmd_fifo_din      (cmd_fifo_din),
        .cmd_size          (cmd_size),
        .op_en             (op_en),
        .busy              (busy),
        .err_bad_op        (err_bad_op),
        .err_overflow      (err_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic        pad;
        logic [7:0]  s1;
        logic [15:0] s2;
        logic [15:0] ich;
        logic [15:0] och;
        logic [7:0]  ik;
        logic [7:0]  ok;
        logic [31:0] wa;
        logic [31:0] da;
        logic [31:0] wb;
    } desc_t;

    int errors = 0;
    int checks = 0;

    // model state
    logic [31:0] exp_q[$];
    int model_cnt = 0;
    bit exp_bad = 1'b0;
    bit exp_ovf = 1'b0;
    int words = 0;
    int cyc = 0;
    int busy_cyc = 0;
    int last_cmd_cyc = -10;
    int op_en_cyc = -10;
    int op_en_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: outputs are compared first (they reflect earlier edges), then
    // this cycle's write and handshake update the model for the next edge.
    always @(negedge clk) begin
        if (rst_n) begin
            cyc++;
            if (busy) busy_cyc++;
            chk("cmd_size", 32'(cmd_size), 32'(model_cnt));
            chk("err_bad_op", 32'(err_bad_op), 32'(exp_bad));
            chk("err_overflow", 32'(err_overflow), 32'(exp_ovf));
            chk("wr_en_while_full", 32'(cmd_fifo_wr_en & cmd_fifo_full), 32'd0);
            if (cmd_fifo_wr_en) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: din 0x%08h, want no write", cmd_fifo_din);
                end else begin
                    chk("fifo_word", cmd_fifo_din, exp_q.pop_front());
                    words++;
                    if (words % 6 == 0) begin
                        model_cnt++;
                        last_cmd_cyc = cyc;
                    end
                end
            end
            if (op_en) begin
                op_en_cnt++;
                op_en_cyc = cyc;
            end
            if (desc_valid && desc_ready) begin
                if (op_type == 3'd0 || op_type > 3'd5) exp_bad = 1'b1;
                else if (model_cnt >= 127)             exp_ovf = 1'b1;
                else begin
                    exp_q.push_back({stride_2, stride_1, 4'h0, padding, op_type});
                    exp_q.push_back({o_channel_size, i_channel_size});
                    exp_q.push_back({8'h00, o_kernel_size, 8'h00, i_kernel_size});
                    exp_q.push_back(weight_start_addr);
                    exp_q.push_back(data_start_addr);
                    exp_q.push_back(writeback_addr);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_desc(input desc_t d);
        int n = 0;
        step();
        op_type = d.op;            padding = d.pad;
        stride_1 = d.s1;           stride_2 = d.s2;
        i_channel_size = d.ich;    o_channel_size = d.och;
        i_kernel_size = d.ik;      o_kernel_size = d.ok;
        weight_start_addr = d.wa;  data_start_addr = d.da;
        writeback_addr = d.wb;
        desc_valid = 1'b1;
        @(negedge clk);
        while (!desc_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!desc_ready) begin
            checks++;
            errors++;
            $display("FAIL send_desc_timeout: desc_ready 0 after %0d cycles, want 1", n);
        end
        step();
        desc_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL wait_idle_timeout: busy 1 after %0d cycles, want 0", n);
        end
    endtask

    task automatic wait_op_en();
        int n = 0;
        while (!op_en && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!op_en) begin
            checks++;
            errors++;
            $display("FAIL op_en_timeout: op_en 0 after %0d cycles, want 1", n);
        end
    endtask

    task automatic do_clear();
        step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        model_cnt = 0;
        exp_bad = 1'b0;
        exp_ovf = 1'b0;
    endtask

    task automatic do_seal();
        step();
        seal = 1'b1;
        step();
        seal = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wr_en"}, 32'(cmd_fifo_wr_en), 32'd0);
        chk({tag, "_din"}, cmd_fifo_din, 32'd0);
        chk({tag, "_cmd_size"}, 32'(cmd_size), 32'd0);
        chk({tag, "_op_en"}, 32'(op_en), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_desc_ready"}, 32'(desc_ready), 32'd0);
        chk({tag, "_err_bad_op"}, 32'(err_bad_op), 32'd0);
        chk({tag, "_err_overflow"}, 32'(err_overflow), 32'd0);
    endtask

    initial begin
        desc_t d1, d2, dd;
        logic [31:0] lit [6];
        int b0, w0, c0, k, n;

        d1 = '{op: 3'd2, pad: 1'b1, s1: 8'hE0, s2: 16'hC400, ich: 16'd3, och: 16'd64,
               ik: 8'd3, ok: 8'd3, wa: 32'h1000, da: 32'hA0000, wb: 32'hC0000};
        d2 = '{op: 3'd4, pad: 1'b0, s1: 8'h10, s2: 16'h0100, ich: 16'd8, och: 16'd8,
               ik: 8'd3, ok: 8'd1, wa: 32'h2000, da: 32'h3000, wb: 32'h4000};
        lit = '{32'hC400E00A, 32'h00400003, 32'h00030003,
                32'h00001000, 32'h000A0000, 32'h000C0000};

        // reset state
        #12;
        chk_all_zero("reset");
        step();
        rst_n = 1'b1;

        // 1: single descriptor, no backpressure
        b0 = busy_cyc;
        send_desc(d1);
        k = 0;
        n = 0;
        while (k < 6 && n < 50) begin
            @(negedge clk);
            n++;
            chk("t1_ready_low", 32'(desc_ready), 32'd0);
            if (cmd_fifo_wr_en) begin
                chk("t1_word", cmd_fifo_din, lit[k]);
                k++;
            end
        end
        chk("t1_write_cycles", 32'(n), 32'd6);
        @(negedge clk);
        chk("t1_cmd_size", 32'(cmd_size), 32'd1);
        chk("t1_ready_back", 32'(desc_ready), 32'd1);
        chk("t1_busy_cycles", 32'(busy_cyc - b0), 32'd6);

        // 2: full for 3 cycles starting at beat 2
        b0 = busy_cyc;
        send_desc(d1);
        step();
        step();
        cmd_fifo_full = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("t2_stall_wr_en", 32'(cmd_fifo_wr_en), 32'd0);
            chk("t2_stall_din", cmd_fifo_din, 32'h00030003);
            step();
        end
        cmd_fifo_full = 1'b0;
        wait_idle();
        chk("t2_busy_cycles", 32'(busy_cyc - b0), 32'd9);
        chk("t2_cmd_size", 32'(cmd_size), 32'd2);

        // 3: illegal op types
        w0 = words;
        dd = d1; dd.op = 3'd6;
        send_desc(dd);
        dd.op = 3'd0;
        send_desc(dd);
        @(negedge clk);
        @(negedge clk);
        chk("t3_err_bad_op", 32'(err_bad_op), 32'd1);
        chk("t3_cmd_size", 32'(cmd_size), 32'd2);
        chk("t3_no_writes", 32'(words - w0), 32'd0);
        do_clear();
        @(negedge clk);
        chk("t3_err_cleared", 32'(err_bad_op), 32'd0);
        chk("t3_size_cleared", 32'(cmd_size), 32'd0);
        chk("t3_no_op_en_yet", 32'(op_en_cnt), 32'd0);

        // 4a: seal from IDLE with one command, then hold in SEALED
        send_desc(d1);
        wait_idle();
        c0 = op_en_cnt;
        do_seal();
        @(negedge clk);
        wait_op_en();
        @(negedge clk);
        chk("t4a_single_pulse", 32'(op_en), 32'd0);
        chk("t4a_sealed_ready", 32'(desc_ready), 32'd0);
        chk("t4a_sealed_busy", 32'(busy), 32'd1);
        step();
        desc_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("t4a_hold_ready", 32'(desc_ready), 32'd0);
        end
        step();
        desc_valid = 1'b0;
        chk("t4a_op_en_count", 32'(op_en_cnt - c0), 32'd1);
        do_clear();

        // 4b: three commands, seal during the third burst
        send_desc(d1);
        send_desc(d2);
        c0 = op_en_cnt;
        send_desc(d1);
        do_seal();
        wait_op_en();
        @(negedge clk);
        chk("t4b_op_en_after_last_word", 32'(op_en_cyc - last_cmd_cyc), 32'd1);
        chk("t4b_cmd_size", 32'(cmd_size), 32'd3);
        chk("t4b_sealed_ready", 32'(desc_ready), 32'd0);
        repeat (3) @(negedge clk);
        chk("t4b_op_en_count", 32'(op_en_cnt - c0), 32'd1);
        do_clear();

        // 4c: seal on an empty list is ignored
        c0 = op_en_cnt;
        do_seal();
        repeat (4) @(negedge clk);
        chk("t4c_no_op_en", 32'(op_en_cnt - c0), 32'd0);
        chk("t4c_busy", 32'(busy), 32'd0);

        // 5: fill the list, then one more
        w0 = words;
        for (int i = 0; i < 127; i++) begin
            dd = d1;
            dd.op = 3'(1 + i % 5);
            dd.s1 = 8'(i);
            dd.wa = 32'(i) << 4;
            dd.wb = 32'hF000_0000 | 32'(i);
            send_desc(dd);
        end
        wait_idle();
        send_desc(d2);
        wait_idle();
        @(negedge clk);
        chk("t5_cmd_size", 32'(cmd_size), 32'd127);
        chk("t5_err_overflow", 32'(err_overflow), 32'd1);
        chk("t5_words", 32'(words - w0), 32'd762);
        do_clear();

        // 6: reset in the middle of a burst
        send_desc(d1);
        send_desc(d2);
        wait_idle();
        send_desc(d1);
        step();
        step();
        step();
        #1;
        rst_n = 1'b0;
        #1;
        chk_all_zero("t6_async");
        exp_q.delete();
        words = 0;
        model_cnt = 0;
        exp_bad = 1'b0;
        exp_ovf = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        send_desc(d2);
        n = 0;
        @(negedge clk);
        while (!cmd_fifo_wr_en && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t6_first_word", cmd_fifo_din, 32'h01001004);
        wait_idle();
        @(negedge clk);
        chk("t6_cmd_size", 32'(cmd_size), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
